// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : PLL reset pulse, lock qualification and ordered domain reset release
// Revision : 1.0
// ============================================================================
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 256,
    parameter int RELEASE_GAP    = 8,
    parameter int N_DOMAINS      = 3,
    parameter int MAX_RETRIES    = 4
) (
    input  logic                 clk_25MHz,
    input  logic                 reset,
    input  logic                 pll_locked,
    output logic                 pll_reset,
    output logic [N_DOMAINS-1:0] domain_rst,
    output logic                 all_ready,
    output logic [2:0]           retry_count,
    output logic                 fault
);

    localparam int C_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int C_MAX_B = (RELEASE_GAP > PLL_RST_CYCLES) ? RELEASE_GAP : PLL_RST_CYCLES;
    localparam int C_TMAX  = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    localparam int TW      = $clog2(C_TMAX) + 1;

    localparam logic [TW-1:0] c_rst_len    = TW'(PLL_RST_CYCLES);
    localparam logic [TW-1:0] c_to_last    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] c_stab_last  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] c_gap_last   = TW'(RELEASE_GAP - 1);
    localparam logic [2:0]    c_max_retry  = 3'(MAX_RETRIES);
    localparam logic [2:0]    c_last_dom   = 3'(N_DOMAINS - 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer;
    logic [2:0]            r_idx;
    logic [2:0]            w_idx;
    logic                  r_meta;
    logic                  r_locked_s;
    logic                  w_pll_reset;
    logic [N_DOMAINS-1:0]  w_domain_rst;
    logic                  w_all_ready;
    logic [2:0]            w_retry;
    logic                  w_fault;

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            r_meta     <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_meta     <= pll_locked;
            r_locked_s <= r_meta;
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            r_state     <= S_PLL_RST;
            r_timer     <= '0;
            r_idx       <= '0;
            pll_reset   <= 1'b1;
            domain_rst  <= '1;
            all_ready   <= 1'b0;
            retry_count <= '0;
            fault       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_timer     <= w_timer;
            r_idx       <= w_idx;
            pll_reset   <= w_pll_reset;
            domain_rst  <= w_domain_rst;
            all_ready   <= w_all_ready;
            retry_count <= w_retry;
            fault       <= w_fault;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_timer      = r_timer;
        w_idx        = r_idx;
        w_pll_reset  = pll_reset;
        w_domain_rst = domain_rst;
        w_all_ready  = all_ready;
        w_retry      = retry_count;
        w_fault      = fault;

        case (r_state)
            S_PLL_RST: begin
                w_pll_reset = 1'b1;
                if (r_timer == c_rst_len) begin
                    w_state     = S_WAIT_LOCK;
                    w_pll_reset = 1'b0;
                    w_timer     = '0;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end

            S_WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state = S_STABLE;
                    w_timer = '0;
                end else if (r_timer == c_to_last) begin
                    w_pll_reset = 1'b1;
                    if (retry_count == c_max_retry) begin
                        w_state = S_FAULT;
                        w_fault = 1'b1;
                    end else begin
                        // The entry edge is the first cycle of the new pulse,
                        // so the timer starts at 1 to keep every pulse equal.
                        w_state = S_PLL_RST;
                        w_retry = retry_count + 3'd1;
                        w_timer = TW'(1);
                    end
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end

            S_STABLE: begin
                if (!r_locked_s) begin
                    w_state = S_WAIT_LOCK;
                    w_timer = '0;
                end else if (r_timer == c_stab_last) begin
                    w_state = S_RELEASE;
                    w_timer = '0;
                    w_idx   = '0;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end

            S_RELEASE, S_RUN: begin
                if (!r_locked_s) begin
                    w_state      = S_PLL_RST;
                    w_pll_reset  = 1'b1;
                    w_domain_rst = '1;
                    w_all_ready  = 1'b0;
                    w_retry      = '0;
                    w_timer      = TW'(1);
                end else if (r_state == S_RUN) begin
                    w_all_ready = 1'b1;
                end else begin
                    if (r_timer == '0) begin
                        for (int i = 0; i < N_DOMAINS; i++) begin
                            if (3'(i) == r_idx) begin
                                w_domain_rst[i] = 1'b0;
                            end
                        end
                    end
                    if ((r_idx == c_last_dom) && (r_timer == '0)) begin
                        w_state = S_RUN;
                    end else if (r_timer == c_gap_last) begin
                        w_timer = '0;
                        w_idx   = r_idx + 3'd1;
                    end else begin
                        w_timer = r_timer + 1'b1;
                    end
                end
            end

            S_FAULT: begin
                w_pll_reset  = 1'b1;
                w_domain_rst = '1;
                w_all_ready  = 1'b0;
                w_fault      = 1'b1;
            end

            default: begin
                w_state = S_PLL_RST;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Directed bench for pll_reset_sequencer with default parameters
// Revision : 1.0
// ============================================================================
module tb_pll_reset_sequencer;

    logic       clk_25MHz;
    logic       reset;
    logic       pll_locked;
    logic       pll_reset;
    logic [2:0] domain_rst;
    logic       all_ready;
    logic [2:0] retry_count;
    logic       fault;

    int errors = 0;
    int checks = 0;
    int cyc    = -1;

    pll_reset_sequencer dut (
        .clk_25MHz   (clk_25MHz),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .pll_reset   (pll_reset),
        .domain_rst  (domain_rst),
        .all_ready   (all_ready),
        .retry_count (retry_count),
        .fault       (fault)
    );

    initial clk_25MHz = 1'b0;
    always #5 clk_25MHz = ~clk_25MHz;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after rising edge number k (cycle 0 = first edge with reset low).
    task automatic step_to(input int k);
        while (cyc < k) begin
            @(posedge clk_25MHz);
            cyc++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        check("rst_pll_reset", pll_reset, 1);
        check("rst_domain_rst", domain_rst, 3'b111);
        check("rst_all_ready", all_ready, 0);
        check("rst_retry", retry_count, 0);
        check("rst_fault", fault, 0);
        reset = 1'b0;
        cyc   = -1;
    endtask

    task automatic nominal_sequence(input string pfx);
        step_to(0);
        check({pfx, "_pll_reset_c0"}, pll_reset, 1);
        step_to(15);
        check({pfx, "_pll_reset_c15"}, pll_reset, 1);
        step_to(16);
        check({pfx, "_pll_reset_c16"}, pll_reset, 0);
        step_to(19);
        pll_locked = 1'b1;
        step_to(278);
        check({pfx, "_dom_c278"}, domain_rst, 3'b111);
        step_to(279);
        check({pfx, "_dom_c279"}, domain_rst, 3'b110);
        step_to(286);
        check({pfx, "_dom_c286"}, domain_rst, 3'b110);
        step_to(287);
        check({pfx, "_dom_c287"}, domain_rst, 3'b100);
        step_to(294);
        check({pfx, "_dom_c294"}, domain_rst, 3'b100);
        step_to(295);
        check({pfx, "_dom_c295"}, domain_rst, 3'b000);
        check({pfx, "_ready_c295"}, all_ready, 0);
        step_to(296);
        check({pfx, "_ready_c296"}, all_ready, 1);
        check({pfx, "_retry_c296"}, retry_count, 0);
        check({pfx, "_fault_c296"}, fault, 0);
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;

        // Nominal lock at cycle 20
        do_reset();
        nominal_sequence("nom");

        // Asynchronous reset between the first and second domain releases
        do_reset();
        step_to(19);
        pll_locked = 1'b1;
        step_to(285);
        check("async_pre_dom", domain_rst, 3'b110);
        #3;
        reset = 1'b1;
        #1;
        check("async_pll_reset", pll_reset, 1);
        check("async_dom", domain_rst, 3'b111);
        check("async_ready", all_ready, 0);
        do_reset();
        nominal_sequence("restart");

        // Single timeout, then lock on the retry
        do_reset();
        step_to(4111);
        check("retry_pll_reset_c4111", pll_reset, 0);
        check("retry_cnt_c4111", retry_count, 0);
        step_to(4112);
        check("retry_pll_reset_c4112", pll_reset, 1);
        check("retry_cnt_c4112", retry_count, 1);
        step_to(4127);
        check("retry_pll_reset_c4127", pll_reset, 1);
        step_to(4128);
        check("retry_pll_reset_c4128", pll_reset, 0);
        step_to(4139);
        pll_locked = 1'b1;
        step_to(4398);
        check("retry_dom_c4398", domain_rst, 3'b111);
        step_to(4399);
        check("retry_dom_c4399", domain_rst, 3'b110);
        step_to(4415);
        check("retry_ready_c4415", all_ready, 0);
        step_to(4416);
        check("retry_ready_c4416", all_ready, 1);
        check("retry_cnt_c4416", retry_count, 1);

        // Permanent lock failure leads to FAULT after five timeouts
        do_reset();
        step_to(20559);
        check("fault_pre_fault", fault, 0);
        check("fault_pre_retry", retry_count, 4);
        check("fault_pre_pll_reset", pll_reset, 0);
        step_to(20560);
        check("fault_fault", fault, 1);
        check("fault_retry", retry_count, 4);
        check("fault_pll_reset", pll_reset, 1);
        check("fault_dom", domain_rst, 3'b111);
        check("fault_ready", all_ready, 0);
        pll_locked = 1'b1;
        step_to(21000);
        check("fault_hold_fault", fault, 1);
        check("fault_hold_dom", domain_rst, 3'b111);
        check("fault_hold_ready", all_ready, 0);
        check("fault_hold_pll_reset", pll_reset, 1);

        // One-cycle glitch 100 cycles into STABLE, then loss of lock in RUN
        do_reset();
        step_to(19);
        pll_locked = 1'b1;
        step_to(121);
        pll_locked = 1'b0;
        step_to(122);
        pll_locked = 1'b1;
        step_to(381);
        check("glitch_dom_c381", domain_rst, 3'b111);
        step_to(382);
        check("glitch_dom_c382", domain_rst, 3'b110);
        check("glitch_retry", retry_count, 0);
        step_to(398);
        check("glitch_ready_c398", all_ready, 0);
        step_to(399);
        check("glitch_ready_c399", all_ready, 1);
        step_to(410);
        check("loss_ready_pre", all_ready, 1);
        pll_locked = 1'b0;
        step_to(412);
        check("loss_ready_c412", all_ready, 1);
        step_to(413);
        check("loss_dom_c413", domain_rst, 3'b111);
        check("loss_ready_c413", all_ready, 0);
        check("loss_pll_reset_c413", pll_reset, 1);
        check("loss_retry_c413", retry_count, 0);
        step_to(428);
        check("loss_pll_reset_c428", pll_reset, 1);
        step_to(429);
        check("loss_pll_reset_c429", pll_reset, 0);
        step_to(439);
        pll_locked = 1'b1;
        step_to(698);
        check("reseq_dom_c698", domain_rst, 3'b111);
        step_to(699);
        check("reseq_dom_c699", domain_rst, 3'b110);
        step_to(716);
        check("reseq_ready_c716", all_ready, 1);
        check("reseq_dom_c716", domain_rst, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the clock-generation PLL from the 25 MHz reference domain.
- Pulses the PLL reset, waits for a stable lock, then releases the downstream clock-domain resets one at a time (12/72/96 MHz by default).
- Retries when lock times out, re-sequences on loss of lock, and latches a fault after too many failed attempts.
- Sits at top level between the PLL primitive or its simulation model and every consumer of the generated clocks.

Parameters:
- PLL_RST_CYCLES, 16, cycles `pll_reset` is held high per attempt (≥1)
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry (≥2)
- STABLE_CYCLES, 256, consecutive synchronized-lock cycles required before release (≥1)
- RELEASE_GAP, 8, cycles between successive domain reset releases (≥1)
- N_DOMAINS, 3, number of downstream domain resets (1..8)
- MAX_RETRIES, 4, failed attempts tolerated before FAULT (0..7)

Ports:
- `clk_25MHz`, in, 1, reference clock; all logic on rising edge
- `reset`, in, 1, asynchronous, active-high; one clock; reset is asynchronous and active-high
- `pll_locked`, in, 1, PLL lock indicator; asynchronous, double-flop synchronized internally
- `pll_reset`, out, 1, active-high reset to the PLL
- `domain_rst`, out, N_DOMAINS, active-high resets; bit 0 releases first
- `all_ready`, out, 1, high while every domain is released and lock holds
- `retry_count`, out, 3, failed lock attempts in the current sequence (saturates at MAX_RETRIES)
- `fault`, out, 1, latched unrecoverable failure

Behaviour:
- All outputs are registered.
- While `reset` is high:
  - state = PLL_RST
  - `pll_reset` = 1
  - `domain_rst` = all 1s
  - `all_ready` = 0
  - `retry_count` = 0
  - `fault` = 0
  - sync flops = 0
  - timers = 0
- Edge numbering: cycle 0 is the first rising edge with `reset` low.
- `locked_s` is `pll_locked` through 2 flops, so it lags by 2 edges.
- PLL_RST:
  - `pll_reset` = 1 for exactly PLL_RST_CYCLES edges: cycles 0..PLL_RST_CYCLES-1 after reset, and the same length on every retry.
  - Then go to WAIT_LOCK; `pll_reset` = 0 and the timer clears.
- WAIT_LOCK:
  - `locked_s` = 1 → STABLE, timer clears.
  - Otherwise the timer increments. When the timer reaches LOCK_TIMEOUT-1 with no lock:
    - if `retry_count` == MAX_RETRIES → FAULT
    - else `retry_count` += 1 and go to PLL_RST
  - Lock arriving on the timeout edge takes priority: go to STABLE, no retry.
- STABLE:
  - Counts consecutive edges with `locked_s` = 1.
  - Any 0 → WAIT_LOCK with the lock timer restarted; `retry_count` unchanged.
  - After STABLE_CYCLES edges → RELEASE.
- RELEASE:
  - `domain_rst[0]` falls on entry.
  - `domain_rst[i]` falls RELEASE_GAP edges after `domain_rst[i-1]`.
  - One edge after the last bit falls → RUN, and `all_ready` rises on that edge.
- Latency requirements, from the first edge sampling `pll_locked` = 1 with no glitch:
  - `domain_rst[0]` falls at L = STABLE_CYCLES + 3 edges
  - `domain_rst[N_DOMAINS-1]` falls at L + (N_DOMAINS-1)·RELEASE_GAP
  - `all_ready` rises one edge later
- Loss of lock (`locked_s` = 0) in RELEASE or RUN, on the next edge:
  - all `domain_rst` = 1 simultaneously
  - `all_ready` = 0
  - `retry_count` = 0
  - go to PLL_RST for a full resequence
- FAULT:
  - `pll_reset` = 1, `domain_rst` all 1s, `all_ready` = 0, `fault` = 1
  - held until `reset`; `pll_locked` is ignored
- `domain_rst` never releases out of order.
- `all_ready` is never high while any `domain_rst` bit or `pll_reset` is high.
- Asynchronous `reset` mid-sequence forces all reset values immediately, without waiting for a clock edge. The sequence restarts from cycle 0 on deassertion.
- Internal timer width: $clog2 of the maximum of LOCK_TIMEOUT, STABLE_CYCLES, RELEASE_GAP and PLL_RST_CYCLES, plus 1. No wrap is permitted in any state.

Test Plan (defaults unless stated):
- Nominal: `pll_locked` rises at cycle 20 and stays high.
  - `pll_reset` is high over cycles 0..15.
  - `domain_rst` = 3'b110 at 279, 3'b100 at 287, 3'b000 at 295.
  - `all_ready` rises at 296; `retry_count` = 0.
- Timeout retry: `pll_locked` stays low until after the first timeout, then rises.
  - `retry_count` = 1.
  - Second `pll_reset` pulse is 16 cycles wide.
  - Release timing is measured from the new lock edge.
- Fault: `pll_locked` is held low.
  - After 5 timeouts, `fault` = 1.
  - `retry_count` = 4; `pll_reset` = 1; `domain_rst` = 3'b111.
  - A later `pll_locked` = 1 has no effect.
- Stability glitch: lock rises, then goes low for 1 cycle at 100 cycles into STABLE.
  - State returns to WAIT_LOCK, then STABLE restarts.
  - `domain_rst[0]` falls 259 cycles after the re-lock edge; `retry_count` = 0.
- Loss in RUN: drop `pll_locked` with `all_ready` = 1.
  - Within 3 edges, `domain_rst` = 3'b111, `all_ready` = 0 and `pll_reset` = 1.
  - Full resequence follows.
- Async reset between the `domain_rst[0]` and `domain_rst[1]` releases:
  - outputs return to reset values before the next clock edge
  - restart matches the nominal timing
